// File: rtl/aes_job_scheduler.sv
// Round-robin scheduler sharing one AES-256 engine between NUM_REQ requesters.
// Holds engine enable per job, aborts on watchdog, enforces an enable-low gap.
module aes_job_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = 2,
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int GAP_CYCLES     = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*128-1:0] req_plaintext,
  input  logic [NUM_REQ*256-1:0] req_key,
  output logic                   eng_enable,
  output logic [127:0]           eng_plaintext,
  output logic [255:0]           eng_key,
  input  logic                   eng_done,
  input  logic [127:0]           eng_ciphertext,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [ID_W-1:0]        resp_id,
  output logic [127:0]           resp_data,
  output logic                   resp_err,
  output logic                   busy
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_RESP,
    S_GAP
  } state_t;

  state_t            r_state;
  logic [PW-1:0]     r_rr;
  logic [15:0]       r_timer;
  logic [GW-1:0]     r_gap;
  logic [ID_W-1:0]   r_tag;
  logic              r_eng_en;
  logic [127:0]      r_pt;
  logic [255:0]      r_key;
  logic              r_resp_valid;
  logic [127:0]      r_resp_data;
  logic              r_resp_err;

  logic [PW-1:0]      w_gnt_idx;
  logic               w_gnt_vld;
  logic [NUM_REQ-1:0] w_ready;
  int                 w_j;

  // Scan downward so the last hit is the first requester after r_rr.
  always_comb begin
    w_gnt_idx = '0;
    w_gnt_vld = 1'b0;
    w_j       = 0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      w_j = (int'(r_rr) + i) % NUM_REQ;
      if (req_valid[w_j]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = PW'(w_j);
      end
    end
  end

  always_comb begin
    w_ready = '0;
    if (r_state == S_IDLE && w_gnt_vld)
      w_ready[w_gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_rr         <= PW'(NUM_REQ - 1);
      r_timer      <= '0;
      r_gap        <= '0;
      r_tag        <= '0;
      r_eng_en     <= 1'b0;
      r_pt         <= '0;
      r_key        <= '0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_gnt_vld) begin
            r_pt     <= req_plaintext[128*int'(w_gnt_idx) +: 128];
            r_key    <= req_key[256*int'(w_gnt_idx) +: 256];
            r_tag    <= ID_W'(w_gnt_idx);
            r_rr     <= w_gnt_idx;
            r_timer  <= '0;
            r_eng_en <= 1'b1;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          if (r_timer != 16'hFFFF)
            r_timer <= r_timer + 16'd1;
          // Done beats a timeout landing in the same cycle.
          if (eng_done) begin
            r_resp_data  <= eng_ciphertext;
            r_resp_err   <= 1'b0;
            r_resp_valid <= 1'b1;
            r_eng_en     <= 1'b0;
            r_state      <= S_RESP;
          end else if (r_timer == 16'(TIMEOUT_CYCLES - 1)) begin
            r_resp_data  <= '0;
            r_resp_err   <= 1'b1;
            r_resp_valid <= 1'b1;
            r_eng_en     <= 1'b0;
            r_state      <= S_RESP;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_gap        <= '0;
            r_state      <= S_GAP;
          end
        end
        S_GAP: begin
          if (r_gap == GW'(GAP_CYCLES - 1))
            r_state <= S_IDLE;
          else
            r_gap <= r_gap + GW'(1);
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready     = w_ready;
  assign eng_enable    = r_eng_en;
  assign eng_plaintext = r_pt;
  assign eng_key       = r_key;
  assign resp_valid    = r_resp_valid;
  assign resp_id       = r_tag;
  assign resp_data     = r_resp_data;
  assign resp_err      = r_resp_err;
  assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_aes_job_scheduler.sv
// Directed bench for aes_job_scheduler with a behavioural engine model.
// Covers single job, round robin, timeout, backpressure, collision, reset.
module tb_aes_job_scheduler;

  localparam logic [127:0] VPT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] VKEY =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] VCT  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] A5   = {16{8'hA5}};

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [3:0]     req_valid = '0;
  logic [3:0]     req_ready;
  logic [511:0]   req_plaintext;
  logic [1023:0]  req_key;
  logic           eng_enable;
  logic [127:0]   eng_plaintext;
  logic [255:0]   eng_key;
  logic           eng_done;
  logic [127:0]   eng_ciphertext;
  logic           resp_valid;
  logic           resp_ready = 1'b1;
  logic [1:0]     resp_id;
  logic [127:0]   resp_data;
  logic           resp_err;
  logic           busy;

  logic [127:0] pt  [4];
  logic [255:0] key [4];

  int n_chk = 0;
  int n_err = 0;

  // engine model
  logic       m_on    = 1'b1;
  logic       m_force = 1'b0;
  int         m_lat   = 5;
  int         m_cnt   = 0;

  function automatic logic [127:0] aes_ref(input logic [127:0] p,
                                           input logic [255:0] k);
    if (p == VPT && k == VKEY) return VCT;
    return p ^ k[255:128] ^ k[127:0];
  endfunction

  always @(posedge clk)
    m_cnt <= eng_enable ? m_cnt + 1 : 0;

  assign eng_done       = m_on && eng_enable && (m_cnt == m_lat);
  assign eng_ciphertext = m_force ? A5 : aes_ref(eng_plaintext, eng_key);
  assign req_plaintext  = {pt[3], pt[2], pt[1], pt[0]};
  assign req_key        = {key[3], key[2], key[1], key[0]};

  always #5 clk = ~clk;

  aes_job_scheduler #(
    .NUM_REQ       (4),
    .ID_W          (2),
    .TIMEOUT_CYCLES(20),
    .GAP_CYCLES    (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_plaintext (req_plaintext),
    .req_key       (req_key),
    .eng_enable    (eng_enable),
    .eng_plaintext (eng_plaintext),
    .eng_key       (eng_key),
    .eng_done      (eng_done),
    .eng_ciphertext(eng_ciphertext),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_id       (resp_id),
    .resp_data     (resp_data),
    .resp_err      (resp_err),
    .busy          (busy)
  );

  task automatic check(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst        = 1'b0;
    req_valid  = '0;
    resp_ready = 1'b1;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic job(input string tag, input int g,
                     input logic [127:0] ed, input logic ee,
                     input int een, input logic [3:0] nv);
    int n;
    int en;
    logic [3:0] exp_rdy;
    #1;
    n = 0;
    while (req_ready == 4'b0 && n < 100) begin
      step();
      n++;
    end
    exp_rdy = 4'b0001 << g;
    check({tag, ":grant"}, req_ready, exp_rdy);
    step();
    check({tag, ":rdy_pulse"}, req_ready, 0);
    check({tag, ":en_rise"}, eng_enable, 1);
    req_valid = nv;
    en = 0;
    n  = 0;
    while (!resp_valid && n < 100) begin
      if (eng_enable) en++;
      step();
      n++;
    end
    check({tag, ":en_cycles"}, en, een);
    check({tag, ":valid"}, resp_valid, 1);
    check({tag, ":id"}, resp_id, g);
    check({tag, ":data"}, resp_data, ed);
    check({tag, ":err"}, resp_err, ee);
    check({tag, ":en_low"}, eng_enable, 0);
    step();
    check({tag, ":valid_drop"}, resp_valid, 0);
  endtask

  initial begin
    int n;
    logic [127:0] bp_d;
    pt[0] = VPT;                     key[0] = VKEY;
    pt[1] = {4{32'h11112222}};       key[1] = {8{32'hdeadbeef}};
    pt[2] = {4{32'h0badf00d}};       key[2] = {8{32'h12345678}};
    pt[3] = {4{32'hcafef00d}};       key[3] = {8{32'h0f1e2d3c}};

    // reset state
    do_reset();
    #1;
    check("rst:ready", req_ready, 0);
    check("rst:en", eng_enable, 0);
    check("rst:pt", eng_plaintext, 0);
    check("rst:key", eng_key, 0);
    check("rst:valid", resp_valid, 0);
    check("rst:id", resp_id, 0);
    check("rst:data", resp_data, 0);
    check("rst:err", resp_err, 0);
    check("rst:busy", busy, 0);

    // single job with the known-answer vector, then gap timing
    req_valid = 4'b0001;
    job("single", 0, VCT, 1'b0, 6, 4'b0001);
    n = 0;
    while (req_ready == 4'b0 && n < 20) begin
      check("gap:en", eng_enable, 0);
      step();
      n++;
    end
    check("gap:cycles", n, 2);
    job("single2", 0, VCT, 1'b0, 6, 4'b0000);

    // round robin
    do_reset();
    req_valid = 4'b1011;
    job("rr0", 0, VCT, 1'b0, 6, 4'b1011);
    job("rr1", 1, aes_ref(pt[1], key[1]), 1'b0, 6, 4'b1011);
    job("rr3", 3, aes_ref(pt[3], key[3]), 1'b0, 6, 4'b1011);
    job("rr0b", 0, VCT, 1'b0, 6, 4'b0000);

    // watchdog timeout
    do_reset();
    m_on = 1'b0;
    req_valid = 4'b0100;
    job("tmo", 2, 128'h0, 1'b1, 20, 4'b0100);
    m_on = 1'b1;
    job("tmo_next", 2, aes_ref(pt[2], key[2]), 1'b0, 6, 4'b0000);

    // response backpressure
    do_reset();
    resp_ready = 1'b0;
    req_valid  = 4'b1001;
    #1;
    check("bp:grant", req_ready, 4'b0001);
    step();
    n = 0;
    while (!resp_valid && n < 100) begin
      step();
      n++;
    end
    bp_d = aes_ref(pt[0], key[0]);
    for (int k = 0; k < 5; k++) begin
      check("bp:valid", resp_valid, 1);
      check("bp:id", resp_id, 0);
      check("bp:data", resp_data, bp_d);
      check("bp:en", eng_enable, 0);
      check("bp:ready", req_ready, 0);
      step();
    end
    resp_ready = 1'b1;
    #1;
    check("bp:valid6", resp_valid, 1);
    step();
    check("bp:xfer", resp_valid, 0);
    req_valid = 4'b1000;
    job("bp_next", 3, aes_ref(pt[3], key[3]), 1'b0, 6, 4'b0000);

    // done and timeout in the same cycle
    do_reset();
    m_lat   = 19;
    m_force = 1'b1;
    req_valid = 4'b0001;
    job("coll", 0, A5, 1'b0, 20, 4'b0000);
    m_force = 1'b0;
    m_lat   = 5;

    // reset during RUN
    do_reset();
    m_on = 1'b0;
    req_valid = 4'b0110;
    #1;
    check("mrst:grant", req_ready, 4'b0010);
    step();
    repeat (10) step();
    check("mrst:running", eng_enable, 1);
    rst = 1'b0;
    step();
    rst  = 1'b1;
    m_on = 1'b1;
    #1;
    check("mrst:en", eng_enable, 0);
    check("mrst:pt", eng_plaintext, 0);
    check("mrst:key", eng_key, 0);
    check("mrst:valid", resp_valid, 0);
    check("mrst:data", resp_data, 0);
    check("mrst:err", resp_err, 0);
    check("mrst:busy", busy, 0);
    check("mrst:regrant", req_ready, 4'b0010);
    job("mrst_job", 1, aes_ref(pt[1], key[1]), 1'b0, 6, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/aes_job_scheduler.md
Name: aes_job_scheduler

Overview:
- Shares one AES-256 encryption engine (plaintext/key in, enable-held operation, one-cycle done pulse with ciphertext) between NUM_REQ requesters.
- Round-robin arbitration across requesters; latches the winner's plaintext and key; holds engine enable for the whole job; enforces a watchdog timeout and a mandatory enable-low gap between jobs.
- Returns results on a single tagged response channel.
- Sits between the host-side request ports and the engine instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ID_W, 2, width of response tag; ID_W >= clog2(NUM_REQ)
- TIMEOUT_CYCLES, 1023, engine cycles allowed from enable rise to done before the job is aborted (1..65535)
- GAP_CYCLES, 2, cycles eng_enable is held low after each job so the engine returns to IDLE (>=1)

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-low (0 = reset)
- req_valid  input  NUM_REQ  per-requester job request
- req_ready  output  NUM_REQ  one-hot accept pulse; a job transfers when valid&ready
- req_plaintext  input  NUM_REQ*128  requester i in bits [128*i+127:128*i]
- req_key  input  NUM_REQ*256  requester i in bits [256*i+255:256*i]
- eng_enable  output  1  engine enable, held high for the entire job
- eng_plaintext  output  128  latched plaintext, stable while eng_enable=1
- eng_key  output  256  latched key, stable while eng_enable=1
- eng_done  input  1  engine one-cycle completion pulse
- eng_ciphertext  input  128  engine result, valid when eng_done=1
- resp_valid  output  1  response available
- resp_ready  input  1  response consumer accept
- resp_id  output  ID_W  index of requester that owns the response
- resp_data  output  128  ciphertext, or 0 on error
- resp_err  output  1  1 = job timed out
- busy  output  1  1 whenever state != IDLE

Behaviour:
- Reset (rst=0 at a clock edge): state=IDLE; req_ready=0; eng_enable=0; eng_plaintext=0; eng_key=0; resp_valid=0; resp_id=0; resp_data=0; resp_err=0; busy=0; timer=0; rr pointer=NUM_REQ-1, so requester 0 wins first. Reset mid-job aborts the job silently; no response is issued.
- State IDLE:
  - If any req_valid is high, grant the first asserted requester searching from rr+1 upward with wrap.
  - In that same cycle: req_ready[g]=1 (combinational from registered state, one cycle only); capture plaintext/key into eng_plaintext/eng_key; store g as the tag; rr<=g; go to RUN.
  - If no req_valid is high, stay in IDLE.
- State RUN:
  - eng_enable=1 registered; it rises on the first RUN cycle and the timer starts at 0, incrementing each cycle.
  - If eng_done=1: latch eng_ciphertext into resp_data; resp_err=0; go to RESP.
  - Else if timer==TIMEOUT_CYCLES-1: resp_data=0; resp_err=1; go to RESP.
  - If done and timeout occur in the same cycle, done wins.
  - eng_done seen outside RUN is ignored.
- State RESP:
  - eng_enable=0; resp_valid=1; resp_id/resp_data/resp_err held stable until resp_valid&resp_ready.
  - On that handshake: resp_valid=0; go to GAP.
  - resp_ready is ignored when resp_valid=0.
- State GAP:
  - eng_enable=0 for GAP_CYCLES cycles counted in GAP; then go to IDLE.
  - No grants are made in RESP or GAP. req_valid may be held by requesters throughout; requests are never dropped.
- Latency: grant at cycle T; eng_enable high from T+1; response valid 1 cycle after the eng_done cycle; next grant no earlier than GAP_CYCLES+1 cycles after the response handshake.
- Fairness: a requester that is continuously valid is served within NUM_REQ jobs.
- eng_plaintext/eng_key hold their last value after a job; they change only on a grant.
- Timer width is 16 bits and it saturates, never wraps; it is cleared on every entry to RUN.

Test Plan:
- Single job: req_valid[0], plaintext 00112233445566778899aabbccddeeff, key 000102…1e1f with the real engine -> req_ready[0] pulses one cycle; resp_valid with resp_id=0, resp_data=8ea2b7ca516745bfeafc49904b496089, resp_err=0; eng_enable low for exactly 2 cycles before the next grant.
- Round robin: req_valid=4'b1011 held, four jobs -> grant order 0,1,3,0; resp_id sequence matches; req_ready is never high in two consecutive cycles.
- Timeout: engine model never pulses done, TIMEOUT_CYCLES=20 -> eng_enable high for exactly 20 cycles; resp_err=1, resp_data=0; the next grant proceeds normally.
- Backpressure: resp_ready low for 5 cycles after resp_valid -> resp_valid/resp_id/resp_data stable all 5 cycles; eng_enable=0; no new req_ready; transfer on the 6th cycle.
- Done/timeout collision: model pulses eng_done=1 with ciphertext A5A5…A5 exactly at timer==TIMEOUT_CYCLES-1 -> resp_err=0, resp_data=A5A5…A5.
- Reset mid-RUN: rst=0 for one cycle 10 cycles into a job -> next cycle all outputs are 0 and state is IDLE; no response issued; with req_valid=4'b0110 still held, requester 1 wins next.
